data_memory: RTL and testbench

Block-level main data memory that sits directly downstream of the data cache and serves its 128-bit block refills and write-backs. It stores one 128-bit block (four RV32 words) per block address and answers each request after a fixed, parameterised latency. It uses a BUSYWAIT handshake: BUSYWAIT is raised in the same cycle a request appears and dropped only in the single cycle when the access is complete.

---
 rtl/rv32_mem_pkg.sv | 17 +
 rtl/data_memory_if.sv | 27 ++
 rtl/dmem_array.sv | 41 ++++
 rtl/data_memory.sv | 140 ++++++++++++++
 tb/tb_data_memory.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared RV32 memory-hierarchy constants and the data-memory FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rv32_mem_pkg;

   localparam int WORD_W       = 32;
   localparam int BLOCK_W      = 128;
   localparam int BLOCK_ADDR_W = 28;

   // Two-bit encoding; the spare code 2'b11 is steered back to IDLE by the FSM.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } dmem_state_t;

endpackage

// File: rtl/data_memory_if.sv
// Cache <-> main-memory block bus: read/write request, block address/data, BUSYWAIT stall.
// Latency: n/a (wiring only).
// Backpressure: the cache holds its request until it sees MEM_BUSYWAIT low.
interface data_memory_if;
   import rv32_mem_pkg::*;

   logic                    MEM_READ;
   logic                    MEM_WRITE;
   logic [BLOCK_ADDR_W-1:0] MEM_BLOCK_ADDR;
   logic [BLOCK_W-1:0]      MEM_WRITE_DATA;
   logic [BLOCK_W-1:0]      MEM_READ_DATA;
   logic                    MEM_BUSYWAIT;
   logic                    MEM_ERROR;

   // Cache side drives requests.
   modport master (
      output MEM_READ, MEM_WRITE, MEM_BLOCK_ADDR, MEM_WRITE_DATA,
      input  MEM_READ_DATA, MEM_BUSYWAIT, MEM_ERROR
   );

   // Memory side answers them.
   modport slave (
      input  MEM_READ, MEM_WRITE, MEM_BLOCK_ADDR, MEM_WRITE_DATA,
      output MEM_READ_DATA, MEM_BUSYWAIT, MEM_ERROR
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port block storage: synchronous write, registered read, read register cleared by reset.
// Latency: write lands on the enabling edge; read data appears after the enabling edge.
// Backpressure: none; the controller sequences every access.
module dmem_array
   import rv32_mem_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [BLOCK_W-1:0]   wdata_i,
   output logic [BLOCK_W-1:0]   rdata_o
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [BLOCK_W-1:0] mem_q [DEPTH];
   logic [BLOCK_W-1:0] rdata_q;

   // Storage is deliberately not reset; contents stay undefined until written.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   // Read register holds the last completed read; reset returns it to zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Block main memory behind the data cache; optional protocol checker under DMEM_PROTO_CHECK_EN.
// Latency: request in IDLE, LATENCY ACCESS cycles, result in the DONE cycle (LATENCY+1 after request).
// Backpressure: MEM_BUSYWAIT high from the request cycle through the last ACCESS cycle, low only in DONE.
module data_memory
   import rv32_mem_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 5
) (
   input  logic         CLK,
   input  logic         RESET,
   data_memory_if.slave bus
);

   dmem_state_t            state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   op_wr_q, op_wr_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [BLOCK_W-1:0]     wdata_q, wdata_d;
   logic                   busy;
   logic                   arr_we;
   logic                   arr_re;
   logic [BLOCK_W-1:0]     rdata;
   logic                   req;

   // Upper block-address bits alias onto the decoded range.
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.MEM_BLOCK_ADDR[BLOCK_ADDR_W-1:ADDR_BITS];

   assign req = bus.MEM_READ | bus.MEM_WRITE;

   // State, countdown and latched request; reset abandons any access in flight.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Next state, stall output and array strobes; ACCESS only looks at latched values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      busy    = 1'b0;
      arr_we  = 1'b0;
      arr_re  = 1'b0;
      case (state_q)
         IDLE: begin
            busy = req;
            if (req) begin
               state_d = ACCESS;
               cnt_d   = 4'(LATENCY - 1);
               op_wr_d = bus.MEM_WRITE;       // write wins when both are raised
               addr_d  = bus.MEM_BLOCK_ADDR[ADDR_BITS-1:0];
               wdata_d = bus.MEM_WRITE_DATA;
            end
         end
         ACCESS: begin
            busy = 1'b1;
            if (cnt_q == 4'd0) begin
               arr_we  = op_wr_q;
               arr_re  = ~op_wr_q;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            busy    = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy    = req;
            state_d = IDLE;
         end
      endcase
      // While reset is held the stall follows the idle equation and nothing is committed.
      if (RESET) begin
         busy   = req;
         arr_we = 1'b0;
         arr_re = 1'b0;
      end
   end

   dmem_array #(
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .we_i    (arr_we),
      .re_i    (arr_re),
      .addr_i  (addr_q),
      .wdata_i (wdata_q),
      .rdata_o (rdata)
   );

   assign bus.MEM_READ_DATA = rdata;
   assign bus.MEM_BUSYWAIT  = busy;

`ifdef DMEM_PROTO_CHECK_EN
   logic err_q, err_d;

   // Sticky error: both requests at once in IDLE, or request withdrawn mid-access.
   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && bus.MEM_READ && bus.MEM_WRITE) begin
         err_d = 1'b1;
      end
      if (state_q == ACCESS && !req) begin
         err_d = 1'b1;
      end
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.MEM_ERROR = err_q;
`else
   assign bus.MEM_ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory with a timeline-based reference model and per-cycle compare.
// Latency: LATENCY=5, ADDR_BITS=8.
// Backpressure: driver holds each request until MEM_BUSYWAIT is seen low.
module tb_data_memory;
   import rv32_mem_pkg::*;

   localparam int L = 5;
`ifdef DMEM_PROTO_CHECK_EN
   localparam bit PROTO = 1'b1;
`else
   localparam bit PROTO = 1'b0;
`endif

   logic CLK;
   logic RESET;
   data_memory_if bus();

   data_memory #(.ADDR_BITS(8), .LATENCY(L)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: one active request described by its start cycle.
   int           cyc = 0;
   bit           act_on = 1'b0;
   int           act_start = 0;
   bit           act_wr = 1'b0;
   logic [7:0]   act_addr = '0;
   logic [127:0] act_data = '0;
   logic [127:0] mem_m [256];
   logic [127:0] exp_rdata = '0;
   logic         exp_err = 1'b0;
   logic         exp_busy;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic next_cyc();
      @(posedge CLK);
      #1;
   endtask

   // Model: request at cycle k=0, commit on the edge ending k=L, DONE at k=L+1.
   always @(posedge CLK) begin
      int k;
      if (RESET) begin
         act_on    = 1'b0;
         exp_rdata = '0;
         exp_err   = 1'b0;
      end else if (act_on) begin
         k = cyc - act_start;
         if (PROTO && k == 0 && bus.MEM_READ && bus.MEM_WRITE) exp_err = 1'b1;
         if (PROTO && k >= 1 && k <= L && !bus.MEM_READ && !bus.MEM_WRITE) exp_err = 1'b1;
         if (k == L) begin
            if (act_wr) mem_m[act_addr] = act_data;
            else        exp_rdata = mem_m[act_addr];
         end
      end
      cyc++;
   end

   // Compare process: checks every output on every falling edge.
   always @(negedge CLK) begin
      int k;
      k = cyc - act_start;
      if (RESET)                      exp_busy = bus.MEM_READ | bus.MEM_WRITE;
      else if (act_on && k <= L + 1)  exp_busy = (k <= L);
      else                            exp_busy = bus.MEM_READ | bus.MEM_WRITE;
      chk("busywait", 128'(bus.MEM_BUSYWAIT), 128'(exp_busy));
      if (!RESET) begin
         chk("read_data", bus.MEM_READ_DATA, exp_rdata);
         chk("error", 128'(bus.MEM_ERROR), 128'(exp_err));
      end
   end

   task automatic start_req(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d);
      bus.MEM_READ       = rd;
      bus.MEM_WRITE      = wr;
      bus.MEM_BLOCK_ADDR = a;
      bus.MEM_WRITE_DATA = d;
      act_start = cyc;
      act_wr    = wr;
      act_addr  = a[7:0];
      act_data  = d;
      act_on    = 1'b1;
   endtask

   // Issue one request (called just after a rising edge); returns stall length and DONE cycle.
   task automatic do_req(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d,
                         output int busy_cycles, output int done_cyc);
      bit done;
      start_req(rd, wr, a, d);
      busy_cycles = 0;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (bus.MEM_BUSYWAIT) busy_cycles++;
         else begin
            done = 1'b1;
            break;
         end
      end
      done_cyc = cyc;
      chk("busywait_released", 128'(done), 128'(1));
      next_cyc();
      bus.MEM_READ  = 1'b0;
      bus.MEM_WRITE = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      int b0, b1, d0, d1;
      logic [127:0] d_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      logic [127:0] d_aa = {32{4'hA}};
      logic [127:0] d_11 = {32{4'h1}};
      logic [127:0] d_22 = {32{4'h2}};
      logic [127:0] d_c0 = 128'hC0C0_0000_1111_2222_3333_4444_5555_6666;
      logic [127:0] d_b0 = 128'hB0B0_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999;
      logic [127:0] d_99 = 128'h9999_0000_0000_0000_0000_0000_0000_0009;

      bus.MEM_READ = 1'b0;
      bus.MEM_WRITE = 1'b0;
      bus.MEM_BLOCK_ADDR = '0;
      bus.MEM_WRITE_DATA = '0;
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      chk("reset_busywait", 128'(bus.MEM_BUSYWAIT), 128'(0));
      chk("reset_read_data", bus.MEM_READ_DATA, 128'(0));
      chk("reset_error", 128'(bus.MEM_ERROR), 128'(0));
      next_cyc();

      // Write then read block 0x05.
      do_req(1'b0, 1'b1, 28'h05, d_a, b0, d0);
      chk("write_busy_len", 128'(b0), 128'(6));
      do_req(1'b1, 1'b0, 28'h05, '0, b0, d0);
      chk("read_busy_len", 128'(b0), 128'(6));
      chk("read_05", bus.MEM_READ_DATA, d_a);

      // Aliasing: 0x105 decodes to 0x05.
      do_req(1'b0, 1'b1, 28'h105, d_aa, b0, d0);
      do_req(1'b1, 1'b0, 28'h05, '0, b0, d0);
      chk("alias_read_05", bus.MEM_READ_DATA, d_aa);

      // Back-to-back write-back then refill.
      do_req(1'b0, 1'b1, 28'h20, d_c0, b0, d0);
      do_req(1'b0, 1'b1, 28'h10, d_b0, b0, d0);
      do_req(1'b1, 1'b0, 28'h20, '0, b1, d1);
      chk("b2b_second_busy_len", 128'(b1), 128'(6));
      chk("b2b_done_spacing", 128'(d1 - d0), 128'(7));
      chk("b2b_read_20", bus.MEM_READ_DATA, d_c0);

      // Reset in ACCESS cycle 3 of a write abandons it.
      do_req(1'b0, 1'b1, 28'h07, d_11, b0, d0);
      start_req(1'b0, 1'b1, 28'h07, d_22);
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b1;
      bus.MEM_WRITE = 1'b0;
      next_cyc();
      RESET = 1'b0;
      @(negedge CLK);
      chk("abort_busywait_idle", 128'(bus.MEM_BUSYWAIT), 128'(0));
      chk("abort_read_data_zero", bus.MEM_READ_DATA, 128'(0));
      next_cyc();
      do_req(1'b1, 1'b0, 28'h07, '0, b0, d0);
      chk("abort_busy_len", 128'(b0), 128'(6));
      chk("abort_read_07", bus.MEM_READ_DATA, d_11);

      // Request withdrawn during ACCESS still completes.
      start_req(1'b1, 1'b0, 28'h05, '0);
      d0 = cyc;
      repeat (2) @(posedge CLK);
      #1 bus.MEM_READ = 1'b0;
      b0 = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (!bus.MEM_BUSYWAIT) break;
         b0++;
      end
      chk("drop_done_cycle", 128'(cyc - d0), 128'(6));
      chk("drop_read_05", bus.MEM_READ_DATA, d_aa);
      chk("drop_error", 128'(bus.MEM_ERROR), 128'(PROTO));
      next_cyc();
      RESET = 1'b1;
      next_cyc();
      RESET = 1'b0;

      // Read and write together: write wins, checker flags it.
      do_req(1'b1, 1'b1, 28'h09, d_99, b0, d0);
      chk("both_error", 128'(bus.MEM_ERROR), 128'(PROTO));
      do_req(1'b1, 1'b0, 28'h09, '0, b0, d0);
      chk("both_read_09", bus.MEM_READ_DATA, d_99);
      chk("both_error_sticky", 128'(bus.MEM_ERROR), 128'(PROTO));
      RESET = 1'b1;
      next_cyc();
      RESET = 1'b0;
      @(negedge CLK);
      chk("error_cleared", 128'(bus.MEM_ERROR), 128'(0));
      next_cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
